true_dual_port_ram: RTL
=======================

# true_dual_port_ram

Parametrised true dual-port synchronous RAM that succeeds the fixed 8x16 dual-address RAM. Both ports can read and write independently. Read data is registered with a valid flag. A per-port read-during-write mode is selectable. After every reset a hardware sequencer clears the whole array to zero. The block serves as the shared scratch memory between two datapath masters on a single clock domain.

## Interface
- DATA_W, 8, data width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W is a derived localparam
- RW_MODE, 0, same-port read-during-write behaviour: 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- port_en_0 / port_en_1  in  1  port access strobe
- wr_en_0 / wr_en_1  in  1  write when 1, read when 0; qualified by port_en_x
- addr_in_0 / addr_in_1  in  ADDR_W  word address
- data_in_0 / data_in_1  in  DATA_W  write data
- data_out_0 / data_out_1  out  DATA_W  registered read data
- rd_valid_0 / rd_valid_1  out  1  one-cycle pulse; data_out_x updated by a read
- collision  out  1  one-cycle pulse; both ports wrote the same address
- init_busy  out  1  clear sequence in progress; port accesses are ignored while high

## Operation
- FSM states: INIT, READY.
- Reset (rst_n=0 at an edge) sets:
  - state=INIT, clear counter=0, init_busy=1
  - data_out_x=0, rd_valid_x=0, collision=0
  - no array write
- INIT:
  - Each edge with rst_n=1 writes 0 to mem[counter], then counter+1.
  - The edge that writes DEPTH-1 moves the FSM to READY and sets init_busy=0.
  - port_en_x is ignored; rd_valid_x and collision stay 0.
- READY, port x with port_en_x=1, wr_en_x=0:
  - data_out_x <= mem[addr_in_x]
  - rd_valid_x <= 1
- READY, port x with port_en_x=1, wr_en_x=1:
  - mem[addr_in_x] <= data_in_x
  - rd_valid_x <= 0
  - data_out_x per RW_MODE: WRITE_FIRST gives data_in_x; READ_FIRST gives the old mem[addr_in_x]; NO_CHANGE holds its value.
- port_en_x=0: data_out_x holds its value, rd_valid_x <= 0.
- Both ports write the same address: port 0's data is stored and collision <= 1.
- One port writes while the other reads the same address: the reading port returns the old contents (read-before-write across ports).
- Both ports read the same address: both return the same data; no collision.
- Addresses are always in range, so there is no wrap handling; the clear counter stops at DEPTH-1.
- Reset asserted mid-INIT or mid-traffic: the next edge aborts everything and the clear restarts from address 0. Any write presented on the reset edge is dropped.

## Timing
- Read latency is 1 cycle: address at edge N, data_out_x/rd_valid_x valid after edge N.
- A write is visible to the other port's read at edge N+1 or later.
- init_busy falls after exactly DEPTH edges with rst_n=1 (16 for the defaults). The first accepted access is at the edge where init_busy is sampled 0.
- collision and rd_valid_x are single-cycle pulses registered at the access edge. Back-to-back accesses give back-to-back pulses.
- No combinational path from any input to any output.

## Structure
- Package ram_pkg holds:
  - RW_MODE constants: RW_WRITE_FIRST=0, RW_READ_FIRST=1, RW_NO_CHANGE=2
  - FSM state typedef: INIT, READY
- Sub-module ram_init_seq (parameter ADDR_W):
  - contains the clear FSM and counter
  - outputs init_busy, clr_we, clr_addr
- The top level muxes the clear write over port 0's write path and holds the storage array and both port registers.

## Test plan
All scenarios use DATA_W=8, ADDR_W=4.
- Reset, then idle: init_busy=1 for 16 cycles then 0. Reading addresses 0..15 on port 1 returns 0x00 each, with rd_valid_1 pulsing one cycle after each address.
- Port 0 writes data i+1 to address i for i=0..15, then port 1 reads 0..15: data_out_1 = 0x01..0x10 in order, 1-cycle latency.
- At the same edge, port 0 writes 0xAA and port 1 writes 0x55, both to address 3: collision pulses once; a later read of address 3 returns 0xAA.
- mem[5]=0x11; port 0 writes 0x22 to address 5 while port 1 reads address 5: data_out_1=0x11, and a read on the next cycle returns 0x22. Repeat the port 0 write for each RW_MODE: data_out_0 is 0x22 (WRITE_FIRST), 0x11 (READ_FIRST), or unchanged (NO_CHANGE).
- Write 0x7E to address 9, then assert rst_n=0 at INIT cycle 4 of a fresh clear and release it: init_busy stays high for 16 more cycles, and address 9 then reads 0x00.
- Port accesses driven while init_busy=1: no rd_valid pulse, and the memory contents are unaffected.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and types for the true dual-port RAM.
// Read-during-write modes and clear-sequencer states.
package ram_pkg;

  localparam int RW_WRITE_FIRST = 0;
  localparam int RW_READ_FIRST  = 1;
  localparam int RW_NO_CHANGE   = 2;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset clear sequencer for the RAM array.
// Walks every address once, writing zero, then parks in READY.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  // State and clear-counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and clear-write decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    clr_addr  = cnt;
    init_busy = 1'b0;
    unique case (state)
      INIT: begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        if (cnt == LAST) begin
          state_nxt = READY;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      READY: begin
        init_busy = 1'b0;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

endmodule

// File: rtl/true_dual_port_ram.sv
// Parametrised true dual-port synchronous RAM.
// Registered reads, selectable read-during-write, cleared after reset.
module true_dual_port_ram
  import ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int RW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              port_en_0,
  input  logic              port_en_1,
  input  logic              wr_en_0,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] addr_in_0,
  input  logic [ADDR_W-1:0] addr_in_1,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic              rd_valid_0,
  output logic              rd_valid_1,
  output logic              collision,
  output logic              init_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              acc_0, acc_1;
  logic              uw_0, uw_1;
  logic              we_0;
  logic [ADDR_W-1:0] wa_0;
  logic [DATA_W-1:0] wd_0;

  ram_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_init (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign ready = ~init_busy;
  assign acc_0 = ready & port_en_0;
  assign acc_1 = ready & port_en_1;
  assign uw_0  = acc_0 & wr_en_0;
  assign uw_1  = acc_1 & wr_en_1;

  // Clear sequence borrows port 0's write path
  assign we_0 = clr_we | uw_0;
  assign wa_0 = clr_we ? clr_addr : addr_in_0;
  assign wd_0 = clr_we ? '0 : data_in_0;

  // Array writes; port 0 listed last so it wins a collision
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (uw_1) mem[addr_in_1] <= data_in_1;
      if (we_0) mem[wa_0] <= wd_0;
    end
  end

  // Port 0 output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_0 <= '0;
      rd_valid_0 <= 1'b0;
    end else begin
      rd_valid_0 <= acc_0 & ~wr_en_0;
      if (acc_0 && !wr_en_0) begin
        data_out_0 <= mem[addr_in_0];
      end else if (uw_0) begin
        if (RW_MODE == RW_WRITE_FIRST) begin
          data_out_0 <= data_in_0;
        end else if (RW_MODE == RW_READ_FIRST) begin
          data_out_0 <= mem[addr_in_0];
        end
      end
    end
  end

  // Port 1 output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_1 <= '0;
      rd_valid_1 <= 1'b0;
    end else begin
      rd_valid_1 <= acc_1 & ~wr_en_1;
      if (acc_1 && !wr_en_1) begin
        data_out_1 <= mem[addr_in_1];
      end else if (uw_1) begin
        if (RW_MODE == RW_WRITE_FIRST) begin
          data_out_1 <= data_in_1;
        end else if (RW_MODE == RW_READ_FIRST) begin
          data_out_1 <= mem[addr_in_1];
        end
      end
    end
  end

  // Same-address double write flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision <= 1'b0;
    end else begin
      collision <= uw_0 & uw_1 & (addr_in_0 == addr_in_1);
    end
  end

endmodule
